// File: rtl/serial_add_arbiter_if.sv
// Bundle of request/operand inputs and result outputs of the shared bit-serial adder.
// Clients drive the master side; the arbiter implements the slave side.
interface serial_add_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             sub0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             sub1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output req0, a0, b0, sub0, req1, a1, b1, sub1,
    input  gnt, busy, done, done_id, result, carry_out, overflow
  );

  modport slave (
    input  req0, a0, b0, sub0, req1, a1, b1, sub1,
    output gnt, busy, done, done_id, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter sharing one full-adder cell between two clients; operands are
// streamed LSB-first through the cell with a carry flop, one bit per cycle.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_arbiter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             id_q;
  logic             last_q;
  logic [1:0]       gnt_q;
  logic             done_q;
  logic             done_id_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;

  logic             any_req;
  logic             win_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;
  logic             cell_sum;
  logic             cell_carry;
  logic [WIDTH-1:0] acc_d;

  // Winner: the lone requester, or the one not served last when both ask.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win_id  = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
    sel_a   = win_id ? bus.a1 : bus.a0;
    sel_b   = win_id ? bus.b1 : bus.b0;
    sel_sub = win_id ? bus.sub1 : bus.sub0;
  end

  always_comb begin
    cell_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    cell_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    acc_d      = {cell_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            id_q    <= win_id;
            a_q     <= sel_a;
            // Subtraction as a + ~b + 1: the +1 enters through the carry flop.
            b_q     <= sel_sub ? ~sel_b : sel_b;
            carry_q <= sel_sub;
            cnt_q   <= '0;
            gnt_q   <= win_id ? 2'b10 : 2'b01;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= cell_carry;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            // carry_q is the carry into the MSB while the MSB is being summed.
            result_q  <= acc_d;
            cout_q    <= cell_carry;
            ovf_q     <= carry_q ^ cell_carry;
            done_q    <= 1'b1;
            done_id_q <= id_q;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          last_q  <= id_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Randomized bench for serial_add_arbiter: an arithmetic/timing reference model
// predicts grants, busy, done and results every cycle.
module tb_serial_add_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_add_arbiter_if #(.WIDTH(W)) bus ();

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Plain integer arithmetic reference for one operation.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, t;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (sub) begin
      r = W'(ua - ub);
      c = (ua >= ub);
      t = sa - sb;
    end else begin
      r = W'(ua + ub);
      c = ((ua + ub) >= (1 << W));
      t = sa + sb;
    end
    v = (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
  endfunction

  // Model state: cycles left in the current op, last served, pending and held results.
  int           rem;
  logic         last_m;
  logic         p_id, p_c, p_v;
  logic [W-1:0] p_r;
  logic         h_id, h_c, h_v;
  logic [W-1:0] h_r;

  initial begin
    logic [1:0] exp_gnt;
    logic       exp_done;
    logic       id;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rem = 0; last_m = 1'b1;
        h_id = 0; h_c = 0; h_v = 0; h_r = '0;
        check_val("rst_gnt", bus.gnt, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_result", bus.result, 0);
        check_val("rst_flags", {bus.done_id, bus.carry_out, bus.overflow}, 0);
      end else begin
        exp_gnt  = 2'b00;
        exp_done = 1'b0;
        if (rem == 0 && (bus.req0 || bus.req1)) begin
          id = (bus.req0 && bus.req1) ? ~last_m : bus.req1;
          last_m  = id;
          exp_gnt = id ? 2'b10 : 2'b01;
          p_id    = id;
          if (id) ref_op(bus.a1, bus.b1, bus.sub1, p_r, p_c, p_v);
          else    ref_op(bus.a0, bus.b0, bus.sub0, p_r, p_c, p_v);
          rem = W + 1;
        end else if (rem > 0) begin
          rem--;
          if (rem == 1) begin
            exp_done = 1'b1;
            h_id = p_id; h_r = p_r; h_c = p_c; h_v = p_v;
          end
        end
        check_val("gnt", bus.gnt, exp_gnt);
        check_val("busy", bus.busy, rem > 0);
        check_val("done", bus.done, exp_done);
        check_val("done_id", bus.done_id, h_id);
        check_val("result", bus.result, h_r);
        check_val("carry_out", bus.carry_out, h_c);
        check_val("overflow", bus.overflow, h_v);
        if (bus.done)
          $display("op done id=%0d result=0x%02h carry=%0d ovf=%0d", bus.done_id, bus.result,
                   bus.carry_out, bus.overflow);
      end
    end
  end

  task automatic scramble();
    bus.a0   = W'($urandom);
    bus.b0   = W'($urandom);
    bus.sub0 = 1'($urandom_range(0, 1));
    bus.a1   = W'($urandom);
    bus.b1   = W'($urandom);
    bus.sub1 = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    check_val("idle_wait", bus.busy, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    check_val("done_wait", bus.done, 1);
  endtask

  // One-cycle request; operands are scrambled right after the grant edge.
  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    wait_idle();
    if (id) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sub1 = sub; end
    else    begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sub0 = sub; end
    @(negedge clk);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    scramble();
  endtask

  initial begin
    logic [1:0] exp_alt;
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 8'h5A, 8'h3C, 1'b0);
    wait_done();
    check_val("t1_result", bus.result, 8'h96);
    check_val("t1_flags", {bus.done_id, bus.carry_out, bus.overflow}, 3'b001);

    issue(1'b1, 8'h10, 8'h20, 1'b1);
    wait_done();
    check_val("t2_result", bus.result, 8'hF0);
    check_val("t2_flags", {bus.done_id, bus.carry_out, bus.overflow}, 3'b100);

    issue(1'b0, 8'hFF, 8'h01, 1'b0);
    wait_done();
    check_val("t3a_result", bus.result, 8'h00);
    check_val("t3a_flags", {bus.carry_out, bus.overflow}, 2'b10);
    issue(1'b0, 8'h7F, 8'hFF, 1'b1);
    wait_done();
    check_val("t3b_result", bus.result, 8'h80);
    check_val("t3b_ovf", bus.overflow, 1);

    // Both requesters held continuously from reset.
    rst_n    = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_alt = 2'b01;
    for (int i = 0; i < 4 * (W + 2) + 2; i++) begin
      @(negedge clk);
      scramble();
      if (bus.gnt != 2'b00) begin
        check_val("t4_alt", bus.gnt, exp_alt);
        exp_alt = ~exp_alt;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Request from client 1 arrives mid-run of a client 0 op.
    issue(1'b0, 8'h33, 8'h44, 1'b0);
    repeat (3) @(negedge clk);
    bus.req1 = 1'b1;
    bus.a1   = 8'hC3;
    bus.b1   = 8'h3D;
    bus.sub1 = 1'b1;
    for (int i = 0; i < 30 && bus.gnt != 2'b10; i++) @(negedge clk);
    check_val("t5_gnt1", bus.gnt, 2'b10);
    bus.req1 = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.req0 = ($urandom_range(0, 3) == 0);
      bus.req1 = ($urandom_range(0, 3) == 0);
      scramble();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Reset in the middle of a run aborts the op.
    issue(1'b0, 8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_busy", bus.busy, 0);
    check_val("t6_outs", {bus.gnt, bus.done, bus.done_id, bus.carry_out, bus.overflow}, 0);
    check_val("t6_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 8'h81, 8'h02, 1'b1);
    wait_done();
    check_val("t6_new_result", bus.result, 8'h7F);
    check_val("t6_new_flags", {bus.done_id, bus.carry_out, bus.overflow}, 3'b111);

    wait_idle();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
